// File: rtl/exec_unit_mc.sv
// exec_unit_mc: handshaked multi-cycle execute stage.
// Sits between register-read and write-back. It accepts one instruction at a
// time and returns the write-register address, the write-back value and the
// next PC. Loads read a synchronous byte-lane data memory. Stores write it.
// R-type func 12 runs an iterative shift-add multiply.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready high only when idle)
//   ins, pc, reg1, reg2   instruction word, word-indexed PC, rs and rt values
//   out_valid / out_ready downstream handshake; outputs are held until taken
//   wra, result, nextpc   write-register (0 = none), write-back value, next PC
module exec_unit_mc #(
   parameter int XLEN               = 32,
   parameter int DMEM_AW            = 8,
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     ins,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] reg1,
   input  logic [XLEN-1:0] reg2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      wra,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] nextpc
);
   localparam int LANES     = XLEN / 8;
   localparam int DEPTH     = 1 << DMEM_AW;
   localparam int MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;
   localparam int CW        = $clog2(MUL_STEPS + 1);

   typedef enum logic [2:0] {IDLE, EXEC, LOAD, MUL, HOLD} state_t;

   state_t            state_reg;
   logic [31:0]       ins_reg;
   logic [XLEN-1:0]   pc_reg, r1_reg, r2_reg;
   logic [XLEN-1:0]   mul_acc_reg, mul_a_reg, mul_b_reg;
   logic [CW-1:0]     mul_cnt_reg;

   // Decode of the captured instruction
   logic [5:0]        op;
   logic [4:0]        rt, rd, shamt, func, alu_fn, wra_next;
   logic [XLEN-1:0]   imm, op2, pc_inc, alu_res, exec_res, load_res, nextpc_next;
   logic [XLEN-1:0]   mul_part, rd_data;
   logic              is_load, is_mul, taken, mem_we;
   logic [LANES-1:0]  lane_mask;
   logic [DMEM_AW-1:0] mem_idx;

   assign op      = ins_reg[31:26];
   assign rt      = ins_reg[20:16];
   assign rd      = ins_reg[15:11];
   assign shamt   = ins_reg[10:6];
   assign func    = ins_reg[4:0];
   assign imm     = {{(XLEN-16){ins_reg[15]}}, ins_reg[15:0]};
   assign op2     = (op == 6'd0) ? r2_reg : imm;
   assign pc_inc  = pc_reg + XLEN'(1);
   assign is_load = (op == 6'd16) || (op == 6'd18) || (op == 6'd20);
   assign is_mul  = (op == 6'd0) && (func == 5'd12);
   assign in_ready = (state_reg == IDLE);

   always_comb begin
      case (op)
         6'd0:    alu_fn = func;
         6'd1:    alu_fn = 5'd0;
         6'd4:    alu_fn = 5'd8;
         6'd5:    alu_fn = 5'd9;
         6'd6:    alu_fn = 5'd10;
         default: alu_fn = 5'd31;
      endcase
   end

   always_comb begin
      case (alu_fn)
         5'd0:    alu_res = r1_reg + op2;
         5'd1:    alu_res = r1_reg - op2;
         5'd8:    alu_res = r1_reg & op2;
         5'd9:    alu_res = r1_reg | op2;
         5'd10:   alu_res = r1_reg ^ op2;
         5'd11:   alu_res = ~(r1_reg & op2);
         5'd16:   alu_res = r1_reg << shamt;
         5'd17:   alu_res = r1_reg >> shamt;
         5'd18:   alu_res = $signed(r1_reg) >>> shamt;
         default: alu_res = '1;
      endcase
   end

   always_comb begin
      case (op)
         6'd0, 6'd1, 6'd4, 6'd5, 6'd6: exec_res = alu_res;
         6'd3:    exec_res = imm << 16;
         6'd41:   exec_res = pc_inc;
         default: exec_res = '1;
      endcase
   end

   always_comb begin
      case (op)
         6'd16:   load_res = rd_data;
         6'd18:   load_res = {{(XLEN-16){rd_data[15]}}, rd_data[15:0]};
         6'd20:   load_res = {{(XLEN-8){rd_data[7]}}, rd_data[7:0]};
         default: load_res = '1;
      endcase
   end

   always_comb begin
      case (op)
         6'd0:    wra_next = rd;
         6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd16, 6'd18, 6'd20: wra_next = rt;
         6'd41:   wra_next = 5'd31;
         default: wra_next = 5'd0;
      endcase
   end

   // Branch compares are unsigned
   always_comb begin
      case (op)
         6'd32:   taken = (r1_reg == r2_reg);
         6'd33:   taken = (r1_reg != r2_reg);
         6'd34:   taken = (r1_reg <  r2_reg);
         6'd35:   taken = (r1_reg <= r2_reg);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         6'd32, 6'd33, 6'd34, 6'd35: nextpc_next = taken ? pc_inc + imm : pc_inc;
         6'd40, 6'd41: nextpc_next = {{(XLEN-26){1'b0}}, ins_reg[25:0]};
         6'd42:   nextpc_next = r1_reg;
         default: nextpc_next = pc_inc;
      endcase
   end

   // Partial product for the bits retired this cycle (low XLEN bits only)
   always_comb begin
      mul_part = '0;
      for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
         if (mul_b_reg[j]) mul_part = mul_part + (mul_a_reg << j);
   end

   // Data memory: one byte array per lane, registered read every cycle.
   // The address wraps: bits above the word index are discarded.
   always_comb begin
      case (op)
         6'd24:   lane_mask = '1;
         6'd26:   lane_mask = LANES'(3);
         6'd28:   lane_mask = LANES'(1);
         default: lane_mask = '0;
      endcase
   end

   assign mem_idx = DMEM_AW'((r1_reg + imm) >> 2);
   // The write happens once, on the edge leaving EXEC, and never under reset
   assign mem_we  = rst_n && (state_reg == EXEC);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
         if (mem_we && lane_mask[gi]) mem[mem_idx] <= r2_reg[8*gi +: 8];
         q_reg <= mem[mem_idx];
      end
      assign rd_data[8*gi +: 8] = q_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         out_valid   <= 1'b0;
         wra         <= '0;
         result      <= '0;
         nextpc      <= '0;
         ins_reg     <= '0;
         pc_reg      <= '0;
         r1_reg      <= '0;
         r2_reg      <= '0;
         mul_acc_reg <= '0;
         mul_a_reg   <= '0;
         mul_b_reg   <= '0;
         mul_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid) begin
               ins_reg   <= ins;
               pc_reg    <= pc;
               r1_reg    <= reg1;
               r2_reg    <= reg2;
               state_reg <= EXEC;
            end
            EXEC: begin
               wra    <= wra_next;
               nextpc <= nextpc_next;
               if (is_load) begin
                  state_reg <= LOAD;
               end else if (is_mul) begin
                  mul_acc_reg <= '0;
                  mul_a_reg   <= r1_reg;
                  mul_b_reg   <= r2_reg;
                  mul_cnt_reg <= CW'(MUL_STEPS);
                  state_reg   <= MUL;
               end else begin
                  result    <= exec_res;
                  out_valid <= 1'b1;
                  state_reg <= HOLD;
               end
            end
            LOAD: begin
               result    <= load_res;
               out_valid <= 1'b1;
               state_reg <= HOLD;
            end
            MUL: begin
               mul_acc_reg <= mul_acc_reg + mul_part;
               mul_a_reg   <= mul_a_reg << MUL_BITS_PER_CYCLE;
               mul_b_reg   <= mul_b_reg >> MUL_BITS_PER_CYCLE;
               mul_cnt_reg <= mul_cnt_reg - CW'(1);
               if (mul_cnt_reg == CW'(1)) begin
                  result    <= mul_acc_reg + mul_part;
                  out_valid <= 1'b1;
                  state_reg <= HOLD;
               end
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: scoreboard bench for exec_unit_mc (XLEN=32, DMEM_AW=8, 1 bit/cycle).
module tb_exec_unit_mc;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] ins = '0, pc = '0, reg1 = '0, reg2 = '0;
   logic        in_ready, out_valid;
   logic [4:0]  wra;
   logic [31:0] result, nextpc;

   exec_unit_mc #(.XLEN(32), .DMEM_AW(8), .MUL_BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ins(ins), .pc(pc), .reg1(reg1), .reg2(reg2),
      .out_valid(out_valid), .out_ready(out_ready),
      .wra(wra), .result(result), .nextpc(nextpc));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins, pc, r1, r2;
      logic [4:0]  wra;
      logic [31:0] res, npc;
      int          lat;
   } txn_t;

   txn_t sb[$];
   int checks = 0, passed = 0;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] sh, input logic [4:0] fn);
      return {6'd0, 10'd0, rd, sh, 1'b0, fn};
   endfunction
   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
      return {op, 5'd0, rt, imm};
   endfunction
   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] a);
      return {op, a};
   endfunction
   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction
   function automatic txn_t mk(input logic [31:0] i, p, a, b, input logic [4:0] w,
                               input logic [31:0] r, n, input int l);
      txn_t t;
      t.ins = i; t.pc = p; t.r1 = a; t.r2 = b; t.wra = w; t.res = r; t.npc = n; t.lat = l;
      return t;
   endfunction

   // Drive one transaction, pushing its expectation, and release in_valid after the accept edge
   task automatic send(input txn_t t);
      @(negedge clk);
      ins = t.ins; pc = t.pc; reg1 = t.r1; reg2 = t.r2; in_valid = 1'b1;
      sb.push_back(t);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges (accept edge included) until out_valid is seen; bounded
   task automatic wait_out(output int lat, output bit tmo, output bit rdy_seen);
      lat = 1; rdy_seen = 1'b0;
      @(negedge clk);
      while (!out_valid && lat <= 200) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      tmo = !out_valid;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_alu();
      txn_t st[$];
      txn_t e;
      int lat; bit tmo, rdy;
      logic [31:0] a = 32'hF0F0_1234, b = 32'h0F0F_00FF;
      st.push_back(mk(i_ins(6'd1, 5'd7, 16'hFFFD), 32'd100, 32'd5, 32'd0, 5'd7, 32'd2, 32'd101, 2));
      st.push_back(mk(r_ins(5'd4, 5'd4, 5'd18), 32'd7, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 32'd8, 2));
      st.push_back(mk(i_ins(6'd5, 5'd8, 16'h8000), 32'd1, a, 32'd0, 5'd8, a | sx(16'h8000), 32'd2, 2));
      st.push_back(mk(i_ins(6'd4, 5'd9, 16'h00FF), 32'd2, a, 32'd0, 5'd9, a & 32'h0000_00FF, 32'd3, 2));
      st.push_back(mk(i_ins(6'd3, 5'd10, 16'h1234), 32'd3, a, 32'd0, 5'd10, 32'h1234_0000, 32'd4, 2));
      st.push_back(mk(r_ins(5'd5, 5'd0, 5'd5), 32'd4, a, b, 5'd5, ONES, 32'd5, 2));
      foreach (st[k]) begin
         send(st[k]);
         wait_out(lat, tmo, rdy);
         e = sb.pop_front();
         checks++; if (tmo || lat !== e.lat) $display("FAIL alu[%0d] latency got %0d want %0d", k, lat, e.lat); else passed++;
         checks++; if (wra !== e.wra) $display("FAIL alu[%0d] wra got %0d want %0d", k, wra, e.wra); else passed++;
         checks++; if (result !== e.res) $display("FAIL alu[%0d] result got %h want %h", k, result, e.res); else passed++;
         checks++; if (nextpc !== e.npc) $display("FAIL alu[%0d] nextpc got %h want %h", k, nextpc, e.npc); else passed++;
         $display("alu[%0d] wra=%0d result=%h nextpc=%h lat=%0d", k, wra, result, nextpc, lat);
         consume();
      end
   endtask

   task automatic test_reset();
      txn_t e;
      int lat; bit tmo, rdy;
      send(mk(r_ins(5'd9, 5'd0, 5'd12), 32'd40, 32'hFFFF, 32'h10001, 5'd9, ONES, 32'd41, 34));
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      sb.delete();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passed++;
      checks++; if (wra !== 5'd0) $display("FAIL reset wra got %0d want 0", wra); else passed++;
      checks++; if (result !== 32'd0) $display("FAIL reset result got %h want 0", result); else passed++;
      checks++; if (nextpc !== 32'd0) $display("FAIL reset nextpc got %h want 0", nextpc); else passed++;
      $display("reset out_valid=%b in_ready=%b wra=%0d result=%h nextpc=%h", out_valid, in_ready, wra, result, nextpc);
      send(mk(r_ins(5'd3, 5'd0, 5'd0), 32'd60, 32'd10, 32'd20, 5'd3, 32'd30, 32'd61, 2));
      wait_out(lat, tmo, rdy);
      e = sb.pop_front();
      checks++; if (tmo || lat !== e.lat) $display("FAIL post_reset latency got %0d want %0d", lat, e.lat); else passed++;
      checks++; if (wra !== e.wra || result !== e.res || nextpc !== e.npc)
         $display("FAIL post_reset outputs got %0d/%h/%h want %0d/%h/%h", wra, result, nextpc, e.wra, e.res, e.npc); else passed++;
      $display("post_reset add wra=%0d result=%h lat=%0d", wra, result, lat);
      consume();
   endtask

   task automatic test_mem();
      txn_t st[$];
      txn_t e;
      int lat; bit tmo, rdy;
      st.push_back(mk(i_ins(6'd24, 5'd0, 16'd0), 32'd200, 32'h40, 32'hAABB_CCDD, 5'd0, ONES, 32'd201, 2));
      st.push_back(mk(i_ins(6'd18, 5'd5, 16'd0), 32'd201, 32'h40, 32'd0, 5'd5, 32'hFFFF_CCDD, 32'd202, 3));
      st.push_back(mk(i_ins(6'd28, 5'd0, 16'd0), 32'd202, 32'h40, 32'h11, 5'd0, ONES, 32'd203, 2));
      st.push_back(mk(i_ins(6'd16, 5'd6, 16'd0), 32'd203, 32'h40, 32'd0, 5'd6, 32'hAABB_CC11, 32'd204, 3));
      st.push_back(mk(i_ins(6'd20, 5'd2, 16'h0001), 32'd204, 32'h3F, 32'd0, 5'd2, 32'h0000_0011, 32'd205, 3));
      st.push_back(mk(i_ins(6'd26, 5'd0, 16'd0), 32'd205, 32'h0, 32'h1234_8765, 5'd0, ONES, 32'd206, 2));
      st.push_back(mk(i_ins(6'd18, 5'd3, 16'd0), 32'd206, 32'h400, 32'd0, 5'd3, 32'hFFFF_8765, 32'd207, 3));
      foreach (st[k]) begin
         send(st[k]);
         wait_out(lat, tmo, rdy);
         e = sb.pop_front();
         checks++; if (tmo || lat !== e.lat) $display("FAIL mem[%0d] latency got %0d want %0d", k, lat, e.lat); else passed++;
         checks++; if (wra !== e.wra) $display("FAIL mem[%0d] wra got %0d want %0d", k, wra, e.wra); else passed++;
         checks++; if (result !== e.res) $display("FAIL mem[%0d] result got %h want %h", k, result, e.res); else passed++;
         checks++; if (nextpc !== e.npc) $display("FAIL mem[%0d] nextpc got %h want %h", k, nextpc, e.npc); else passed++;
         $display("mem[%0d] wra=%0d result=%h nextpc=%h lat=%0d", k, wra, result, nextpc, lat);
         consume();
      end
   endtask

   task automatic test_mul();
      txn_t st[$];
      txn_t e;
      int lat; bit tmo, rdy;
      st.push_back(mk(r_ins(5'd9, 5'd0, 5'd12), 32'd300, 32'hFFFF, 32'h10001, 5'd9, 32'hFFFF_FFFF, 32'd301, 34));
      st.push_back(mk(r_ins(5'd1, 5'd0, 5'd12), 32'd301, 32'h1234_5678, 32'h9ABC_DEF1,
                      5'd1, 32'h1234_5678 * 32'h9ABC_DEF1, 32'd302, 34));
      foreach (st[k]) begin
         send(st[k]);
         wait_out(lat, tmo, rdy);
         e = sb.pop_front();
         checks++; if (tmo || lat !== e.lat) $display("FAIL mul[%0d] latency got %0d want %0d", k, lat, e.lat); else passed++;
         checks++; if (rdy !== 1'b0) $display("FAIL mul[%0d] in_ready_busy got %b want 0", k, rdy); else passed++;
         checks++; if (wra !== e.wra) $display("FAIL mul[%0d] wra got %0d want %0d", k, wra, e.wra); else passed++;
         checks++; if (result !== e.res) $display("FAIL mul[%0d] result got %h want %h", k, result, e.res); else passed++;
         checks++; if (nextpc !== e.npc) $display("FAIL mul[%0d] nextpc got %h want %h", k, nextpc, e.npc); else passed++;
         $display("mul[%0d] wra=%0d result=%h lat=%0d", k, wra, result, lat);
         consume();
      end
   endtask

   task automatic test_branch_jump();
      txn_t st[$];
      txn_t e;
      int lat; bit tmo, rdy;
      st.push_back(mk(i_ins(6'd32, 5'd0, 16'd5), 32'd20, 32'd7, 32'd7, 5'd0, ONES, 32'd26, 2));
      st.push_back(mk(i_ins(6'd33, 5'd0, 16'd5), 32'd20, 32'd7, 32'd7, 5'd0, ONES, 32'd21, 2));
      st.push_back(mk(i_ins(6'd34, 5'd0, 16'hFFFE), 32'd10, 32'd3, 32'd9, 5'd0, ONES, 32'd9, 2));
      st.push_back(mk(i_ins(6'd35, 5'd0, 16'd4), 32'd30, ONES, 32'd1, 5'd0, ONES, 32'd31, 2));
      st.push_back(mk(i_ins(6'd34, 5'd0, 16'd4), 32'd30, 32'd1, ONES, 5'd0, ONES, 32'd35, 2));
      st.push_back(mk(j_ins(6'd41, 26'h100), 32'd50, 32'd0, 32'd0, 5'd31, 32'd51, 32'h100, 2));
      st.push_back(mk(j_ins(6'd40, 26'h3FF_FFFF), 32'd50, 32'd0, 32'd0, 5'd0, ONES, 32'h03FF_FFFF, 2));
      st.push_back(mk(j_ins(6'd42, 26'd0), 32'd50, 32'h1234, 32'd0, 5'd0, ONES, 32'h1234, 2));
      foreach (st[k]) begin
         send(st[k]);
         wait_out(lat, tmo, rdy);
         e = sb.pop_front();
         checks++; if (tmo || lat !== e.lat) $display("FAIL br[%0d] latency got %0d want %0d", k, lat, e.lat); else passed++;
         checks++; if (wra !== e.wra) $display("FAIL br[%0d] wra got %0d want %0d", k, wra, e.wra); else passed++;
         checks++; if (result !== e.res) $display("FAIL br[%0d] result got %h want %h", k, result, e.res); else passed++;
         checks++; if (nextpc !== e.npc) $display("FAIL br[%0d] nextpc got %h want %h", k, nextpc, e.npc); else passed++;
         $display("br[%0d] wra=%0d result=%h nextpc=%h lat=%0d", k, wra, result, nextpc, lat);
         consume();
      end
   endtask

   task automatic test_hold();
      txn_t e;
      int lat; bit tmo, rdy;
      send(mk(i_ins(6'd6, 5'd2, 16'h0FF0), 32'd70, 32'h0000_F0F0, 32'd0, 5'd2, 32'h0000_FF00, 32'd71, 2));
      wait_out(lat, tmo, rdy);
      e = sb.pop_front();
      checks++; if (tmo || lat !== e.lat) $display("FAIL hold latency got %0d want %0d", lat, e.lat); else passed++;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || wra !== e.wra || result !== e.res || nextpc !== e.npc)
            $display("FAIL hold[%0d] v/r/wra/res/npc got %b/%b/%0d/%h/%h want 1/0/%0d/%h/%h",
                     c, out_valid, in_ready, wra, result, nextpc, e.wra, e.res, e.npc);
         else passed++;
         $display("hold[%0d] out_valid=%b in_ready=%b result=%h", c, out_valid, in_ready, result);
         @(negedge clk);
      end
      consume();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL release out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); else passed++;
      $display("release out_valid=%b in_ready=%b", out_valid, in_ready);
   endtask

   task automatic test_back_to_back();
      txn_t st[$];
      txn_t e;
      int lat; bit tmo, rdy;
      logic [31:0] a = 32'hF0F0_1234, b = 32'h0F0F_00FF;
      st.push_back(mk(r_ins(5'd11, 5'd0, 5'd1), 32'd80, a, b, 5'd11, a - b, 32'd81, 2));
      st.push_back(mk(r_ins(5'd12, 5'd0, 5'd8), 32'd81, a, b, 5'd12, a & b, 32'd82, 2));
      st.push_back(mk(r_ins(5'd13, 5'd0, 5'd9), 32'd82, a, b, 5'd13, a | b, 32'd83, 2));
      st.push_back(mk(r_ins(5'd14, 5'd0, 5'd10), 32'd83, a, b, 5'd14, a ^ b, 32'd84, 2));
      st.push_back(mk(r_ins(5'd15, 5'd0, 5'd11), 32'd84, a, b, 5'd15, ~(a & b), 32'd85, 2));
      st.push_back(mk(r_ins(5'd16, 5'd8, 5'd16), 32'd85, a, b, 5'd16, a << 8, 32'd86, 2));
      st.push_back(mk(r_ins(5'd17, 5'd8, 5'd17), 32'd86, a, b, 5'd17, a >> 8, 32'd87, 2));
      st.push_back(mk(r_ins(5'd18, 5'd8, 5'd18), 32'd87, 32'h7000_0000, b, 5'd18, 32'h0070_0000, 32'd88, 2));
      out_ready = 1'b1;
      foreach (st[k]) begin
         send(st[k]);
         wait_out(lat, tmo, rdy);
         e = sb.pop_front();
         checks++; if (tmo || lat !== e.lat) $display("FAIL b2b[%0d] latency got %0d want %0d", k, lat, e.lat); else passed++;
         checks++; if (wra !== e.wra || result !== e.res || nextpc !== e.npc)
            $display("FAIL b2b[%0d] wra/res/npc got %0d/%h/%h want %0d/%h/%h", k, wra, result, nextpc, e.wra, e.res, e.npc);
         else passed++;
         $display("b2b[%0d] wra=%0d result=%h nextpc=%h lat=%0d", k, wra, result, nextpc, lat);
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      test_alu();
      test_reset();
      test_mem();
      test_mul();
      test_branch_jump();
      test_hold();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
